mem_bus_responder: RTL and testbench

- Memory-module end of the system bus: answers CPU read/write cycles on the active-low bus lines (dr_, dw_, ds_, dnb_, dad_, ddt_, dqb_).
- Responds with OK (accepted), EN (no memory / rejected) or PE (parity error).
- Holds a word-addressed RAM plus a per-block page map translating (NB, page) into a physical 4K-word frame.
- Sits on the bus alongside the CPU; the CPU's rok_/ren_/rpe_/rdt_ are driven from this block's outputs.

---
 rtl/mem_bus_responder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mem_bus_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
//
// Memory-module end of the system bus. Answers CPU read/write cycles presented
// on active-low bus lines, translating (block number, page) through a per-block
// page map into a physical 4K-word frame of an internal word-addressed RAM.
// Each cycle is answered with OK (accepted), EN (rejected / no memory) or,
// when parity is built in, PE (parity error on read).
//
// Optional feature (compile-time macro MEM_PARITY_EN):
//   defined   - RAM words carry an odd-parity bit (bit 16) generated on write;
//               a read whose stored parity mismatches drives pe_ low together
//               with ok_. Extra input par_inj inverts the stored parity bit of
//               a write while high.
//   undefined - no parity storage, no par_inj port, pe_ is constant 1.
//
// Ports:
//   __clk        system clock
//   reset        synchronous active-high reset
//   dr_, dw_     read / write request (active low)
//   ds_          request strobe (active low); address/data valid while low
//   dqb_         user-mode qualifier (active low); user cycles may not use NB 0
//   dnb_[3:0]    block number (active low)
//   dad_[15:0]   word address (active low); top nibble page, low 12 bits offset
//   ddt_[15:0]   write data (active low)
//   ok_, en_, pe_  response lines (active low)
//   rdt_[15:0]   read data (active low); all ones when not driving
//   cfg_we       page-map write strobe (active high)
//   cfg_nb, cfg_page, cfg_frame, cfg_valid  page-map entry being written
//   par_inj      (MEM_PARITY_EN only) invert stored parity on write
//   o_dbg_state  current FSM state, for observation
//
// Handshake: a cycle starts when the synchronized ds_ is seen low in IDLE with
// exactly one of dr_/dw_ low. The response (ok_ or en_) is held until the
// synchronized ds_ is seen high; the following RELEASE cycle drops every
// response line back to 1 before the next request may be accepted.
// -----------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int FRAMES  = 4,
    parameter int ACC_LAT = 3,
    parameter int FRAME_W = 4
) (
    input  logic               __clk,
    input  logic               reset,
    input  logic               dr_,
    input  logic               dw_,
    input  logic               ds_,
    input  logic               dqb_,
    input  logic [3:0]         dnb_,
    input  logic [15:0]        dad_,
    input  logic [15:0]        ddt_,
    output logic               ok_,
    output logic               en_,
    output logic               pe_,
    output logic [15:0]        rdt_,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_nb,
    input  logic [3:0]         cfg_page,
    input  logic [FRAME_W-1:0] cfg_frame,
    input  logic               cfg_valid,
`ifdef MEM_PARITY_EN
    input  logic               par_inj,
`endif
    output logic [2:0]         o_dbg_state
);

    localparam int FI_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DEPTH = FRAMES * 4096;
    localparam int PA_W  = FI_W + 12;
    localparam int CNT_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [FRAME_W:0] FRAMES_L = (FRAME_W + 1)'(FRAMES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_LAT - 1);
`ifdef MEM_PARITY_EN
    localparam int RAM_W = 17;
`else
    localparam int RAM_W = 16;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_ACK     = 3'd3,
        ST_REJECT  = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    // ---------------------------------------------------------------- sync
    // All bus lines share one 2-flop synchronizer; released value is all ones.
    logic [39:0] w_bus_in;
    logic [39:0] r_sync1;
    logic [39:0] r_sync2;

    assign w_bus_in = {dr_, dw_, ds_, dqb_, dnb_, dad_, ddt_};

    logic        w_dr;
    logic        w_dw;
    logic        w_ds;
    logic        w_dqb;
    logic [3:0]  w_dnb;
    logic [15:0] w_dad;
    logic [15:0] w_ddt;

    assign w_dr  = r_sync2[39];
    assign w_dw  = r_sync2[38];
    assign w_ds  = r_sync2[37];
    assign w_dqb = r_sync2[36];
    assign w_dnb = r_sync2[35:32];
    assign w_dad = r_sync2[31:16];
    assign w_ddt = r_sync2[15:0];

    // ------------------------------------------------------------ state regs
    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_write;
    logic              r_qb;
    logic [3:0]        r_nb;
    logic [15:0]       r_addr;
    logic [15:0]       r_data;
    logic [FI_W-1:0]   r_frame;

    logic              w_latch;
    logic              w_load_cnt;
    logic              w_do_access;

    // ------------------------------------------------------------- page map
    // Flat 256-entry map indexed by {nb, page}.
    logic               r_map_valid [256];
    logic [FRAME_W-1:0] r_map_frame [256];

    logic [7:0]         w_map_idx;
    logic               w_entry_valid;
    logic [FRAME_W-1:0] w_entry_frame;
    logic               w_frame_oob;
    logic               w_reject_dec;

    assign w_map_idx     = {r_nb, r_addr[15:12]};
    assign w_entry_valid = r_map_valid[w_map_idx];
    assign w_entry_frame = r_map_frame[w_map_idx];
    assign w_frame_oob   = ({1'b0, w_entry_frame} >= FRAMES_L);
    assign w_reject_dec  = !w_entry_valid || w_frame_oob || (r_qb && (r_nb == 4'd0));

    // Reset map: NB0 pages below FRAMES identity-mapped, all else invalid.
    // A cfg write lands at the clock edge, so a DECODE in the same cycle
    // still reads the previous entry.
    always_ff @(posedge __clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                r_map_valid[i] <= (i < FRAMES);
                r_map_frame[i] <= (i < FRAMES) ? FRAME_W'(i) : '0;
            end
        end else if (cfg_we) begin
            r_map_valid[{cfg_nb, cfg_page}] <= cfg_valid;
            r_map_frame[{cfg_nb, cfg_page}] <= cfg_frame;
        end
    end

    // ------------------------------------------------------------------ RAM
    logic [RAM_W-1:0] r_mem [DEPTH];
    logic [RAM_W-1:0] r_rdata;
    logic [PA_W-1:0]  w_phys;
    logic [RAM_W-1:0] w_wr_word;

    assign w_phys = {r_frame, r_addr[11:0]};

`ifdef MEM_PARITY_EN
    // Odd parity: the 17-bit stored word always has an odd number of ones.
    assign w_wr_word = {(~(^r_data)) ^ par_inj, r_data};
`else
    assign w_wr_word = r_data;
`endif

    // The write is gated by reset so a cycle interrupted by reset never commits.
    always_ff @(posedge __clk) begin
        if (w_do_access && r_is_write && !reset) begin
            r_mem[w_phys] <= w_wr_word;
        end
        if (w_do_access && !r_is_write) begin
            r_rdata <= r_mem[w_phys];
        end
    end

    // --------------------------------------------------------- sequential
    always_ff @(posedge __clk) begin
        if (reset) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_qb       <= 1'b0;
            r_nb       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_frame    <= '0;
        end else begin
            r_sync1 <= w_bus_in;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            // Request lines are captured once; later changes are ignored.
            if (w_latch) begin
                r_is_write <= ~w_dw;
                r_qb       <= ~w_dqb;
                r_nb       <= ~w_dnb;
                r_addr     <= ~w_dad;
                r_data     <= ~w_ddt;
            end
            if (w_load_cnt) begin
                r_cnt   <= CNT_LOAD;
                r_frame <= w_entry_frame[FI_W-1:0];
            end else if (r_state == ST_ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------- next state and outputs
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_load_cnt   = 1'b0;
        w_do_access  = 1'b0;
        ok_          = 1'b1;
        en_          = 1'b1;
        pe_          = 1'b1;
        rdt_         = 16'hFFFF;

        case (r_state)
            ST_IDLE: begin
                if (!w_ds) begin
                    // Exactly one of dr_/dw_ low is a legal request.
                    if (w_dr ^ w_dw) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_DECODE;
                    end else begin
                        w_state_next = ST_REJECT;
                    end
                end
            end
            ST_DECODE: begin
                if (w_ds) begin
                    w_state_next = ST_RELEASE;
                end else if (w_reject_dec) begin
                    w_state_next = ST_REJECT;
                end else begin
                    w_load_cnt   = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An abandoned cycle wins over the final access cycle so a
                // write is only committed while the strobe is still held.
                if (w_ds) begin
                    w_state_next = ST_RELEASE;
                end else if (r_cnt == '0) begin
                    w_do_access  = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                ok_ = 1'b0;
                if (!r_is_write) begin
                    rdt_ = ~r_rdata[15:0];
`ifdef MEM_PARITY_EN
                    pe_ = ^r_rdata;
`endif
                end
                if (w_ds) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_REJECT: begin
                en_ = 1'b0;
                if (w_ds) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_responder
//
// Directed bench for mem_bus_responder (FRAMES=4, ACC_LAT=3, FRAME_W=4).
// Inputs are driven just after a falling clock edge; outputs are sampled on
// falling edges. A request driven at falling edge N0 is first sampled at the
// next rising edge; counting from that edge, ok_ falls 6 edges later, so it is
// still 1 at falling edge N6 and 0 at N7. ok_ rises 2 edges after the first
// edge that samples ds_ high: still 0 two falling edges after release, 1 at
// the third.
// -----------------------------------------------------------------------------
module tb_mem_bus_responder;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        dr_, dw_, ds_, dqb_;
    logic [3:0]  dnb_;
    logic [15:0] dad_, ddt_;
    logic        ok_, en_, pe_;
    logic [15:0] rdt_;
    logic        cfg_we;
    logic [3:0]  cfg_nb, cfg_page;
    logic [3:0]  cfg_frame;
    logic        cfg_valid;
    logic        par_inj;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    mem_bus_responder #(
        .FRAMES (4),
        .ACC_LAT(3),
        .FRAME_W(4)
    ) dut (
        .__clk      (clk),
        .reset      (reset),
        .dr_        (dr_),
        .dw_        (dw_),
        .ds_        (ds_),
        .dqb_       (dqb_),
        .dnb_       (dnb_),
        .dad_       (dad_),
        .ddt_       (ddt_),
        .ok_        (ok_),
        .en_        (en_),
        .pe_        (pe_),
        .rdt_       (rdt_),
        .cfg_we     (cfg_we),
        .cfg_nb     (cfg_nb),
        .cfg_page   (cfg_page),
        .cfg_frame  (cfg_frame),
        .cfg_valid  (cfg_valid),
`ifdef MEM_PARITY_EN
        .par_inj    (par_inj),
`endif
        .o_dbg_state(dbg_state)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    task automatic release_bus(input int settle);
        ds_  = 1'b1;
        dr_  = 1'b1;
        dw_  = 1'b1;
        dqb_ = 1'b1;
        dnb_ = '1;
        dad_ = '1;
        ddt_ = '1;
        repeat (settle) @(negedge clk);
    endtask

    task automatic drive_req(input logic r_n, input logic w_n, input logic [3:0] nb,
                             input logic [15:0] addr, input logic [15:0] data,
                             input logic user);
        @(negedge clk);
        dr_  = r_n;
        dw_  = w_n;
        dnb_ = ~nb;
        dad_ = ~addr;
        ddt_ = ~data;
        dqb_ = ~user;
        ds_  = 1'b0;
    endtask

    // Bounded wait for either response line.
    task automatic wait_resp();
        int n;
        n = 0;
        while (ok_ && en_ && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_write(input string tag, input logic [3:0] nb,
                            input logic [15:0] addr, input logic [15:0] data);
        drive_req(1'b1, 1'b0, nb, addr, data, 1'b0);
        wait_resp();
        check(tag, {31'd0, ok_}, 32'd0);
        release_bus(4);
    endtask

    task automatic do_read(input logic [3:0] nb, input logic [15:0] addr, input logic user,
                           output logic o_ok, output logic o_en, output logic o_pe,
                           output logic [15:0] o_rdt);
        drive_req(1'b0, 1'b1, nb, addr, 16'h0000, user);
        wait_resp();
        o_ok  = ok_;
        o_en  = en_;
        o_pe  = pe_;
        o_rdt = rdt_;
        release_bus(4);
    endtask

    task automatic cfg_write(input logic [3:0] nb, input logic [3:0] page,
                             input logic [3:0] frame, input logic valid);
        @(negedge clk);
        cfg_nb    = nb;
        cfg_page  = page;
        cfg_frame = frame;
        cfg_valid = valid;
        cfg_we    = 1'b1;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic        r_ok, r_en, r_pe;
        logic [15:0] r_dt;
        logic        seen;

        reset     = 1'b1;
        cfg_we    = 1'b0;
        cfg_nb    = '0;
        cfg_page  = '0;
        cfg_frame = '0;
        cfg_valid = 1'b0;
        par_inj   = 1'b0;
        release_bus(3);

        // Reset state
        check("rst_ok", {31'd0, ok_}, 32'd1);
        check("rst_en", {31'd0, en_}, 32'd1);
        check("rst_pe", {31'd0, pe_}, 32'd1);
        check("rst_rdt", {16'd0, rdt_}, 32'h0000_FFFF);
        check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write NB0 0x0123 <= 0xBEEF with exact ok_ timing
        drive_req(1'b1, 1'b0, 4'd0, 16'h0123, 16'hBEEF, 1'b0);
        repeat (6) @(negedge clk);
        check("wr_ok_not_yet", {31'd0, ok_}, 32'd1);
        @(negedge clk);
        check("wr_ok_at_6", {31'd0, ok_}, 32'd0);
        check("wr_rdt_released", {16'd0, rdt_}, 32'h0000_FFFF);
        release_bus(4);

        // Read it back, with ok_ release timing
        drive_req(1'b0, 1'b1, 4'd0, 16'h0123, 16'h0000, 1'b0);
        wait_resp();
        check("rd_ok", {31'd0, ok_}, 32'd0);
        check("rd_data", {16'd0, rdt_}, 32'h0000_4110);
        check("rd_pe", {31'd0, pe_}, 32'd1);
        release_bus(2);
        check("rd_ok_held", {31'd0, ok_}, 32'd0);
        @(negedge clk);
        check("rd_ok_rise", {31'd0, ok_}, 32'd1);
        check("rd_rdt_release", {16'd0, rdt_}, 32'h0000_FFFF);
        @(negedge clk);

        // Write NB0 page 1 for later mapped access
        do_write("wr_p1_ok", 4'd0, 16'h1456, 16'h1234);

        // Unmapped NB5 page 2
        do_read(4'd5, 16'h2456, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("unmap_en", {31'd0, r_en}, 32'd0);
        check("unmap_ok", {31'd0, r_ok}, 32'd1);
        check("unmap_rdt", {16'd0, r_dt}, 32'h0000_FFFF);

        // Map NB5 page 2 -> frame 1, read same word as NB0 page 1
        cfg_write(4'd5, 4'd2, 4'd1, 1'b1);
        do_read(4'd5, 16'h2456, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("map_ok", {31'd0, r_ok}, 32'd0);
        check("map_data", {16'd0, r_dt}, 32'h0000_EDCB);

        // User-mode access to NB0
        do_read(4'd0, 16'h0123, 1'b1, r_ok, r_en, r_pe, r_dt);
        check("user_nb0_en", {31'd0, r_en}, 32'd0);
        check("user_nb0_ok", {31'd0, r_ok}, 32'd1);

        // dr_ and dw_ both low: protocol error, RAM untouched
        drive_req(1'b0, 1'b0, 4'd0, 16'h0123, 16'h0000, 1'b0);
        wait_resp();
        check("both_en", {31'd0, en_}, 32'd0);
        check("both_ok", {31'd0, ok_}, 32'd1);
        release_bus(4);
        do_read(4'd0, 16'h0123, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("both_ram_kept", {16'd0, r_dt}, 32'h0000_4110);

        // Page beyond the identity map of NB0 is invalid
        do_read(4'd0, 16'h4000, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("nb0_p4_en", {31'd0, r_en}, 32'd0);

        // Abandoned write: strobe released while counter is 1
        drive_req(1'b1, 1'b0, 4'd0, 16'h0123, 16'h5555, 1'b0);
        repeat (3) @(negedge clk);
        ds_  = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        seen = seen | ~ok_ | ~en_;
        @(negedge clk);
        seen = seen | ~ok_ | ~en_;
        check("abandon_in_access", {29'd0, dbg_state}, {29'd0, S_ACCESS});
        @(negedge clk);
        seen = seen | ~ok_ | ~en_;
        check("abandon_release", {29'd0, dbg_state}, {29'd0, S_RELEASE});
        @(negedge clk);
        seen = seen | ~ok_ | ~en_;
        check("abandon_no_resp", {31'd0, seen}, 32'd0);
        release_bus(3);
        do_read(4'd0, 16'h0123, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("abandon_old_data", {16'd0, r_dt}, 32'h0000_4110);

        // Reset during ACK
        drive_req(1'b0, 1'b1, 4'd0, 16'h0123, 16'h0000, 1'b0);
        wait_resp();
        check("rstack_ok_before", {31'd0, ok_}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rstack_ok", {31'd0, ok_}, 32'd1);
        check("rstack_rdt", {16'd0, rdt_}, 32'h0000_FFFF);
        check("rstack_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        reset = 1'b0;
        release_bus(4);

        // Frame beyond FRAMES is rejected; in-range frame on NB3 works
        cfg_write(4'd3, 4'd0, 4'd7, 1'b1);
        do_read(4'd3, 16'h0010, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("oob_frame_en", {31'd0, r_en}, 32'd0);
        check("oob_frame_ok", {31'd0, r_ok}, 32'd1);
        cfg_write(4'd3, 4'd1, 4'd1, 1'b1);
        do_read(4'd3, 16'h1456, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("nb3_p1_ok", {31'd0, r_ok}, 32'd0);
        check("nb3_p1_data", {16'd0, r_dt}, 32'h0000_EDCB);
        check("nb3_p1_pe", {31'd0, r_pe}, 32'd1);

`ifdef MEM_PARITY_EN
        // Injected parity error
        par_inj = 1'b1;
        do_write("par_wr_inj", 4'd0, 16'h0200, 16'h0001);
        par_inj = 1'b0;
        do_read(4'd0, 16'h0200, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("par_err_ok", {31'd0, r_ok}, 32'd0);
        check("par_err_pe", {31'd0, r_pe}, 32'd0);
        check("par_err_data", {16'd0, r_dt}, 32'h0000_FFFE);
        // Clean rewrite
        do_write("par_wr_clean", 4'd0, 16'h0200, 16'h0001);
        do_read(4'd0, 16'h0200, 1'b0, r_ok, r_en, r_pe, r_dt);
        check("par_ok_pe", {31'd0, r_pe}, 32'd1);
        check("par_ok_data", {16'd0, r_dt}, 32'h0000_FFFE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
